// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit with its own HI/LO registers. An op issued
//   from EX runs for DATA_W+1 cycles in the background: DATA_W radix-2 steps in
//   RUN, then one FIX cycle that applies the sign fix-up and writes HI/LO. The
//   pipeline keeps running meanwhile, and the unit only asks for a stall when
//   ID needs HI/LO or the unit itself.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        EX holds mult/multu/div/divu (one-cycle pulse)
//   op_div_i       1 = divide, 0 = multiply (sampled with start_i)
//   signed_i       1 = signed op (sampled with start_i)
//   operand_a_i    rs: multiplicand / dividend
//   operand_b_i    rt: multiplier / divisor
//   mthi_i/mtlo_i  EX holds mthi/mtlo, write mt_data_i to HI/LO
//   mt_data_i      data for mthi/mtlo
//   hilo_read_i    ID holds mfhi/mflo
//   muldiv_id_i    ID holds mult/multu/div/divu/mthi/mtlo
//   abort_i        flush the in-flight op; HI/LO untouched, no done
//   hi_o/lo_o      HI/LO registers
//   busy_o         high while the FSM is not idle
//   done_o         one-cycle pulse after a completed op wrote HI/LO
//   stall_req_o    combinational stall request to the hazard unit
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              op_div_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  input  logic              mthi_i,
  input  logic              mtlo_i,
  input  logic [DATA_W-1:0] mt_data_i,
  input  logic              hilo_read_i,
  input  logic              muldiv_id_i,
  input  logic              abort_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              stall_req_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc_hi/acc_lo: mul = running {partial product, remaining multiplier};
  //                div = {remainder, dividend-shifting-into-quotient}.
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  // m: |multiplicand| for mul, |divisor| for div.
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] a_raw_q, a_raw_d;
  logic              op_div_q, op_div_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;

  // Operand magnitudes. The most-negative value maps onto itself, which read
  // as unsigned is exactly its magnitude, so no extra bit is needed.
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;

  assign a_neg = signed_i & operand_a_i[DATA_W-1];
  assign b_neg = signed_i & operand_b_i[DATA_W-1];
  assign a_abs = a_neg ? -operand_a_i : operand_a_i;
  assign b_abs = b_neg ? -operand_b_i : operand_b_i;

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right by one.
  logic [DATA_W:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);

  // Restoring divide step. The remainder is always below the divisor, so the
  // subtraction result fits in DATA_W bits whenever it does not borrow.
  logic [DATA_W:0]   div_shift;
  logic              div_borrow;
  logic [DATA_W-1:0] div_diff;
  assign div_shift  = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_borrow = div_shift < {1'b0, m_q};
  assign div_diff   = div_shift[DATA_W-1:0] - m_q;

  // Sign fix-up applied in FIX.
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   res_hi, res_lo;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*DATA_W-1:DATA_W];
    res_lo = prod_fix[DATA_W-1:0];
    if (op_div_q) begin
      if (div0_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_lo = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
        res_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  // Outputs. Start is folded into the stall so a dependent instruction in ID
  // can never slip into EX on the cycle the op is issued.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    stall_req_o = (busy_o | start_i) & (hilo_read_i | muldiv_id_i);
    hi_o        = hi_q;
    lo_o        = lo_q;
    done_o      = done_q;
  end

  // Datapath next-state. Start/mthi/mtlo are only honoured in IDLE; abort
  // freezes everything (including HI/LO) and only returns the FSM to IDLE.
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    a_raw_d  = a_raw_q;
    op_div_d = op_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (!abort_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = op_div_i ? a_abs : b_abs;
            m_d      = op_div_i ? b_abs : a_abs;
            a_raw_d  = operand_a_i;
            op_div_d = op_div_i;
            neg_a_d  = a_neg;
            neg_b_d  = b_neg;
            div0_d   = (operand_b_i == '0);
          end else begin
            if (mthi_i) hi_d = mt_data_i;
            if (mtlo_i) lo_d = mt_data_i;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_div_q) begin
            acc_hi_d = div_borrow ? div_shift[DATA_W-1:0] : div_diff;
            acc_lo_d = {acc_lo_q[DATA_W-2:0], ~div_borrow};
          end else begin
            acc_hi_d = mul_sum[DATA_W:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
          end
        end
        S_FIX: begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      a_raw_q  <= '0;
      op_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      a_raw_q  <= a_raw_d;
      op_div_q <= op_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule
